isi_spike_gen: RTL and testbench



---
 rtl/isi_spike_gen.sv | 103 ++++++++++
 tb/tb_isi_spike_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/isi_spike_gen.sv
// Spike request generator: emits request_z pulses, captures the sampler's reply
// word, and times the next inter-spike interval in prescaled ticks.
module isi_spike_gen #(
    parameter int bit_chip      = 6,
    parameter int pw            = 4,
    parameter int r_main_to_low = 1000,
    parameter int load_delay    = 2,
    parameter int isi_min       = 1,
    parameter int bit_cnt       = 16
) (
    input  logic                clk_main,
    input  logic                rst,
    input  logic                en,
    input  logic [bit_chip-1:0] bit_to_chip,
    output logic                request_z,
    output logic [bit_chip-1:0] isi_q,
    output logic                busy,
    output logic [bit_cnt-1:0]  spike_cnt
);

    localparam int PH_MAX = (pw > load_delay) ? pw : load_delay;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int PS_W   = (r_main_to_low > 1) ? $clog2(r_main_to_low) : 1;
    localparam int TG_W   = bit_chip + 1;

    typedef enum logic [1:0] {IDLE, PULSE, LOAD, COUNT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PH_W-1:0] ph_cnt;
    logic [PS_W-1:0] presc;
    logic [TG_W-1:0] tick_cnt;
    logic [TG_W-1:0] target;
    logic            presc_wrap;
    logic            count_done;

    // One extra bit keeps the all-ones sample plus offset from wrapping.
    assign target     = {1'b0, isi_q} + TG_W'(isi_min);
    assign presc_wrap = (presc == PS_W'(r_main_to_low - 1));
    assign count_done = presc_wrap && ((tick_cnt + TG_W'(1)) == target);

    always_ff @(posedge clk_main) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (en) state_nxt = PULSE;
            PULSE: if (ph_cnt == PH_W'(pw - 1)) state_nxt = LOAD;
            LOAD:  if (ph_cnt == PH_W'(load_delay - 1)) state_nxt = COUNT;
            COUNT: if (count_done) state_nxt = en ? PULSE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk_main) begin
        if (rst) begin
            request_z <= 1'b0;
            busy      <= 1'b0;
            spike_cnt <= '0;
            isi_q     <= '0;
            ph_cnt    <= '0;
            presc     <= '0;
            tick_cnt  <= '0;
        end else begin
            request_z <= (state_nxt == PULSE);
            busy      <= (state_nxt != IDLE);

            if (state_nxt == PULSE && state != PULSE)
                spike_cnt <= spike_cnt + bit_cnt'(1);

            if (state_nxt == state && (state == PULSE || state == LOAD))
                ph_cnt <= ph_cnt + PH_W'(1);
            else
                ph_cnt <= '0;

            if (state == LOAD && state_nxt == COUNT)
                isi_q <= bit_to_chip;

            // Prescaler and tick counter only run while staying in COUNT,
            // so both start from zero on every COUNT entry.
            if (state == COUNT && state_nxt == COUNT) begin
                if (presc_wrap) begin
                    presc    <= '0;
                    tick_cnt <= tick_cnt + TG_W'(1);
                end else begin
                    presc <= presc + PS_W'(1);
                end
            end else begin
                presc    <= '0;
                tick_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_isi_spike_gen.sv
// Directed bench for isi_spike_gen: pw=4, load_delay=2, r_main_to_low=3,
// isi_min=1, bit_chip=6, bit_cnt=4 so the spike counter wraps quickly.
module tb_isi_spike_gen;

    localparam int BC = 6;
    localparam int SC = 4;

    logic          clk_main = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [BC-1:0] bit_to_chip = 6'd5;
    logic          request_z;
    logic [BC-1:0] isi_q;
    logic          busy;
    logic [SC-1:0] spike_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int exp_spk = 0;

    isi_spike_gen #(
        .bit_chip(BC), .pw(4), .r_main_to_low(3),
        .load_delay(2), .isi_min(1), .bit_cnt(SC)
    ) dut (
        .clk_main(clk_main), .rst(rst), .en(en), .bit_to_chip(bit_to_chip),
        .request_z(request_z), .isi_q(isi_q), .busy(busy), .spike_cnt(spike_cnt)
    );

    always #5 clk_main = ~clk_main;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    // Advance until the next request_z rising edge; per = cycles elapsed,
    // hi = high cycles seen, counting the cycle we started in.
    task automatic meas(input int maxc, output int per, output int hi);
        logic prev;
        per  = 0;
        hi   = 1;
        prev = request_z;
        while (per < maxc) begin
            tick();
            per++;
            if (request_z && !prev) break;
            if (request_z) hi++;
            prev = request_z;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        bit_to_chip = 6'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({request_z, busy, isi_q, spike_cnt} !== '0)
                $display("FAIL reset_hold[%0d]: rz=%0d busy=%0d isi=%0d cnt=%0d, want all 0",
                         i, request_z, busy, isi_q, spike_cnt);
            else n_pass++;
        end
        rst = 1'b0;
        tick();
        exp_spk = 1;
        n_chk++;
        if (request_z !== 1'b1 || busy !== 1'b1)
            $display("FAIL reset_first_rise: rz=%0d busy=%0d, want 1 1", request_z, busy);
        else n_pass++;
        n_chk++;
        if (spike_cnt !== SC'(exp_spk))
            $display("FAIL reset_first_cnt: got %0d want %0d", spike_cnt, exp_spk);
        else n_pass++;
    endtask

    task automatic test_steady();
        int per, hi;
        bit_to_chip = 6'd5;
        for (int k = 0; k < 2; k++) begin
            meas(60, per, hi);
            exp_spk++;
            n_chk++;
            if (per !== 24) $display("FAIL steady_period[%0d]: got %0d want 24", k, per);
            else n_pass++;
            n_chk++;
            if (hi !== 4) $display("FAIL steady_width[%0d]: got %0d want 4", k, hi);
            else n_pass++;
            n_chk++;
            if (isi_q !== 6'd5) $display("FAIL steady_isi[%0d]: got %0d want 5", k, isi_q);
            else n_pass++;
            n_chk++;
            if (spike_cnt !== SC'(exp_spk))
                $display("FAIL steady_cnt[%0d]: got %0d want %0d", k, spike_cnt, exp_spk);
            else n_pass++;
        end
    endtask

    task automatic test_extremes();
        int per, hi;
        bit_to_chip = 6'd0;
        for (int i = 0; i < 5; i++) tick();
        n_chk++;
        if (isi_q !== 6'd5) $display("FAIL isi_hold_in_load: got %0d want 5", isi_q);
        else n_pass++;
        tick();
        n_chk++;
        if (isi_q !== 6'd0) $display("FAIL isi_first_count: got %0d want 0", isi_q);
        else n_pass++;
        meas(20, per, hi);
        exp_spk++;
        n_chk++;
        if (per !== 3) $display("FAIL isi0_tail: got %0d want 3", per);
        else n_pass++;

        meas(30, per, hi);
        exp_spk++;
        n_chk++;
        if (per !== 9) $display("FAIL period_isi0: got %0d want 9", per);
        else n_pass++;

        bit_to_chip = 6'd63;
        meas(300, per, hi);
        exp_spk++;
        n_chk++;
        if (per !== 198) $display("FAIL period_isi63: got %0d want 198", per);
        else n_pass++;
        n_chk++;
        if (isi_q !== 6'd63) $display("FAIL isi63_value: got %0d want 63", isi_q);
        else n_pass++;

        bit_to_chip = 6'd10;
        for (int i = 0; i < 7; i++) tick();
        n_chk++;
        if (isi_q !== 6'd10) $display("FAIL toggle_capture: got %0d want 10", isi_q);
        else n_pass++;
        bit_to_chip = 6'd63;
        for (int i = 0; i < 5; i++) tick();
        bit_to_chip = 6'd0;
        meas(100, per, hi);
        exp_spk++;
        n_chk++;
        if (per + 12 !== 39) $display("FAIL toggle_period: got %0d want 39", per + 12);
        else n_pass++;
        n_chk++;
        if (spike_cnt !== SC'(exp_spk))
            $display("FAIL extremes_cnt: got %0d want %0d", spike_cnt, exp_spk);
        else n_pass++;
    endtask

    task automatic test_en_drop();
        int  cyc;
        bit  rose;
        bit_to_chip = 6'd2;
        for (int i = 0; i < 8; i++) tick();
        en = 1'b0;
        cyc  = 8;
        rose = 1'b0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
            if (request_z) rose = 1'b1;
        end
        n_chk++;
        if (cyc !== 15) $display("FAIL en_drop_busy_fall: got %0d want 15", cyc);
        else n_pass++;
        n_chk++;
        if (rose !== 1'b0) $display("FAIL en_drop_no_pulse: rz seen=%0d want 0", rose);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_chk++;
        if (request_z !== 1'b0 || busy !== 1'b0)
            $display("FAIL en_drop_idle: rz=%0d busy=%0d want 0 0", request_z, busy);
        else n_pass++;
        n_chk++;
        if (spike_cnt !== SC'(exp_spk))
            $display("FAIL en_drop_cnt: got %0d want %0d", spike_cnt, exp_spk);
        else n_pass++;
        en = 1'b1;
        tick();
        exp_spk++;
        n_chk++;
        if (request_z !== 1'b1 || busy !== 1'b1)
            $display("FAIL en_reassert: rz=%0d busy=%0d want 1 1", request_z, busy);
        else n_pass++;
        n_chk++;
        if (spike_cnt !== SC'(exp_spk))
            $display("FAIL en_reassert_cnt: got %0d want %0d", spike_cnt, exp_spk);
        else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        tick();
        n_chk++;
        if (request_z !== 1'b1) $display("FAIL mid_pulse_high: got %0d want 1", request_z);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++;
        if ({request_z, busy, isi_q, spike_cnt} !== '0)
            $display("FAIL mid_pulse_reset: rz=%0d busy=%0d isi=%0d cnt=%0d, want all 0",
                     request_z, busy, isi_q, spike_cnt);
        else n_pass++;
        rst = 1'b0;
        tick();
        exp_spk = 1;
        n_chk++;
        if (request_z !== 1'b1 || spike_cnt !== SC'(exp_spk))
            $display("FAIL mid_pulse_restart: rz=%0d cnt=%0d want 1 1", request_z, spike_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int per, hi;
        bit saw_zero;
        saw_zero = 1'b0;
        bit_to_chip = 6'd0;
        for (int k = 0; k < 16; k++) begin
            meas(30, per, hi);
            exp_spk++;
            if (spike_cnt === '0) saw_zero = 1'b1;
            n_chk++;
            if (per !== 9 || hi !== 4)
                $display("FAIL wrap_pulse[%0d]: period=%0d width=%0d want 9 4", k, per, hi);
            else n_pass++;
            n_chk++;
            if (spike_cnt !== SC'(exp_spk))
                $display("FAIL wrap_cnt[%0d]: got %0d want %0d", k, spike_cnt, exp_spk % 16);
            else n_pass++;
        end
        n_chk++;
        if (saw_zero !== 1'b1) $display("FAIL wrap_zero: saw_zero=%0d want 1", saw_zero);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_extremes();
        test_en_drop();
        test_reset_mid_pulse();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
